// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BUSY)
//   OWN_IFETCH  : owner code for requester 0 (instruction fetch)
//   OWN_DATA    : owner code for requester 1 (data access)
//   pick_winner : grant decision for a cycle in IDLE
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam logic OWN_IFETCH = 1'b0;
    localparam logic OWN_DATA   = 1'b1;

    // With both requesters asking, the priority flag names the winner;
    // otherwise whoever is asking wins.
    function automatic logic pick_winner(input logic r0, input logic r1,
                                         input logic prio);
        if (r0 && r1) begin
            return prio;
        end else if (r1) begin
            return OWN_DATA;
        end else begin
            return OWN_IFETCH;
        end
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts BUSY cycles that end without mem_ack and flags
// the cycle in which the transaction has to be abandoned.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
//   clk, rst : clock, synchronous active-high reset
//   start    : grant cycle; the count restarts on entry to BUSY
//   active   : arbiter is in BUSY
//   ack      : memory completes the access this cycle
//   expired  : count has reached TIMEOUT and there is no ack this cycle
module mem_arb_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // An ack in the same cycle as the limit wins, so expiry needs !ack.
    assign expired = active && !ack && (count == CW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (active && !ack && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mux2_1.sv
// mux2_1: two-input multiplexer of configurable width.
//   N  : data width
//   d0 : selected when s = 0
//   d1 : selected when s = 1
//   s  : select
//   y  : output
module mux2_1 #(
    parameter int N = 32
) (
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic         s,
    output logic [N-1:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch
// (requester 0) and data access (requester 1) with round-robin ownership.
// Optional watchdog abort is built when MEM_ARB_TIMEOUT_EN is defined.
//
// Handshake: a requester raises req with we/addr/wdata stable and holds it
// until its done pulse. done is a single-cycle pulse in the cycle the memory
// acks (or the watchdog aborts); rdata is valid only in that cycle. A req
// still high in the IDLE cycle after done is a new request.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req0/req1             : requests
//   we0/we1, addr0/addr1,
//   wdata0/wdata1         : per-requester access fields
//   done0/done1           : completion pulses
//   rdata                 : read data (= mem_rdata)
//   mem_req, mem_we,
//   mem_addr, mem_wdata   : memory port outputs
//   mem_ack, mem_rdata    : memory port inputs
//   sel                   : registered owner, steers the muxes
//   busy                  : FSM state (1 = BUSY), doubles as state debug view
//   err                   : watchdog abort pulse
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N       = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [N-1:0]  wdata0,
    input  logic [N-1:0]  wdata1,
    output logic          done0,
    output logic          done1,
    output logic [N-1:0]  rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    input  logic          mem_ack,
    input  logic [N-1:0]  mem_rdata,
    output logic          sel,
    output logic          busy,
    output logic          err
);

    arb_state_t state, state_next;
    logic       sel_next;
    logic       prio, prio_next;
    logic       grant;
    logic       expired;
    logic       we_muxed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= OWN_IFETCH;
            prio  <= OWN_IFETCH;
        end else begin
            state <= state_next;
            sel   <= sel_next;
            prio  <= prio_next;
        end
    end

    always_comb begin
        state_next = state;
        sel_next   = sel;
        prio_next  = prio;
        grant      = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant      = 1'b1;
                    sel_next   = pick_winner(req0, req1, prio);
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // expired is never set together with mem_ack.
                if (mem_ack || expired) begin
                    done0      = (sel == OWN_IFETCH);
                    done1      = (sel == OWN_DATA);
                    err        = expired;
                    prio_next  = ~sel;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = (state == BUSY);
    assign mem_req = busy;
    assign rdata   = mem_rdata;

    mux2_1 #(.N(AW)) u_addr_mux (
        .d0 (addr0),
        .d1 (addr1),
        .s  (sel),
        .y  (mem_addr)
    );

    mux2_1 #(.N(N)) u_wdata_mux (
        .d0 (wdata0),
        .d1 (wdata1),
        .s  (sel),
        .y  (mem_wdata)
    );

    mux2_1 #(.N(1)) u_we_mux (
        .d0 (we0),
        .d1 (we1),
        .s  (sel),
        .y  (we_muxed)
    );

    // Address and data follow sel at all times; the write strobe is gated
    // so memory never sees a write outside BUSY.
    assign mem_we = busy & we_muxed;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .start   (grant),
        .active  (busy),
        .ack     (mem_ack),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing one memory port between instruction fetch (requester 0) and data access (requester 1) in the multi-cycle MIPS core. A round-robin FSM picks an owner, and the registered owner drives the select of `mux2_1` instances that steer address, write data and write-enable onto the memory port. The arbiter returns a per-requester completion pulse, and optionally aborts hung transactions with a watchdog.

## Interface
Parameters:
- `N`, 32, data width
- `AW`, 32, address width
- `TIMEOUT`, 15, max BUSY cycles without `mem_ack` before abort (watchdog build only); must be ≥1

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0` / `req1`  in  1  request; held high until matching `done`
- `we0` / `we1`  in  1  write enable; stable while req high
- `addr0` / `addr1`  in  AW  address; stable while req high
- `wdata0` / `wdata1`  in  N  write data; stable while req high
- `done0` / `done1`  out  1  one-cycle completion pulse
- `rdata`  out  N  = `mem_rdata`; valid in the cycle of `done`
- `mem_req`  out  1  memory request
- `mem_we`  out  1  muxed write enable
- `mem_addr`  out  AW  muxed address
- `mem_wdata`  out  N  muxed write data
- `mem_ack`  in  1  memory completes the current access this cycle
- `mem_rdata`  in  N  memory read data
- `sel`  out  1  registered owner; also the `mux2_1` select
- `busy`  out  1  high in BUSY
- `err`  out  1  timeout abort pulse

## Operation
- FSM states: IDLE, BUSY.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that requester.
  - Both requesting: grant the requester indicated by priority flag `prio`.
  - Grant action: `sel` ← winner, go to BUSY.
- BUSY:
  - `mem_req=1`, `busy=1`.
  - `mem_addr`, `mem_wdata`, `mem_we` = requester `sel` fields, via `mux2_1`.
- Completion: in BUSY with `mem_ack=1`:
  - `done_sel=1` combinationally that cycle; `rdata` passes `mem_rdata`.
  - Next state IDLE; `prio` ← `~sel`.
- Outputs outside BUSY: `mem_req=0`, `done0=done1=0`, `mem_we=0`; `mem_addr`/`mem_wdata` follow `sel`.
- Requester drops `req` mid-BUSY (illegal): the transaction still completes and `done` still pulses.
- `req` still high in the IDLE cycle after `done`: treated as a new request.
- `rst`: state IDLE, `sel=0`, `prio=0`, watchdog counter 0; any in-flight access is dropped without `done`.

## Timing
- Reset values: `mem_req=0`, `mem_we=0`, `busy=0`, `sel=0`, `done0=done1=0`, `err=0`.
- Grant latency: `req` sampled high at edge t → BUSY and `mem_req=1` from cycle t+1.
- Minimum transaction: 2 cycles (grant, then ack cycle); 1 IDLE bubble between transactions.
- Back-to-back with both requesting: ownership strictly alternates.
- `mem_ack` outside BUSY is ignored.

## Configuration
- Macro `MEM_ARB_TIMEOUT_EN`, defined:
  - Counter of width $clog2(TIMEOUT+1) clears on entry to BUSY and increments each BUSY cycle without ack.
  - When count = `TIMEOUT` and no ack: `err=1` and `done_sel=1` (rdata invalid); go to IDLE; `prio` flips.
  - Ack in the same cycle as timeout: normal completion, `err=0`.
- Undefined: no counter; BUSY waits for `mem_ack` indefinitely; `err` tied 0.

## Structure
- Package `mem_arb_pkg`:
  - State enum {IDLE, BUSY}.
  - Owner constants `OWN_IFETCH=0`, `OWN_DATA=1`.
- Datapath steering: three existing `mux2_1` instances, with N=AW, N=N and N=1.
- New sub-module `mem_arb_watchdog`: counter plus expiry flag; instantiated only under the macro.

## Test plan
- Single request: `req0=1`, `addr0=0x100`, ack 2 cycles after `mem_req` → `mem_addr=0x100`, one `done0` pulse, `sel=0`, no `done1`.
- Simultaneous requests after reset: both `req` high continuously, ack every BUSY cycle → grant order 0,1,0,1; each `done` exactly once per grant.
- Write steering: `req1`, `we1=1`, `wdata1=0xDEADBEEF` → `mem_we=1`, `mem_wdata=0xDEADBEEF`, `sel=1`.
- Read return: `mem_rdata=0xCAFEF00D` with ack for owner 0 → `rdata=0xCAFEF00D` in the same cycle as `done0`.
- Reset mid-BUSY: `rst` pulsed before ack → next cycle `mem_req=0`, `busy=0`, `sel=0`, no `done`; a following dual request grants 0.
- Timeout (macro on, `TIMEOUT=4`): no ack → `err` and `done_sel` pulse on the 5th BUSY cycle (count reaches 4), then IDLE; ack on that exact cycle → `err=0`.
